ctrl_envase: RTL and testbench
==============================

Name: ctrl_envase

Overview:
Sequencer for one bottling station: conveyor motor, fill valve and capper. The controller moves a bottle into position, fills it, caps it and counts it. It watches each step with a timeout and latches a fault that requires operator acknowledge. It sits between the panel inputs (start/stop/ack) and the actuators, and replaces the free-running three-phase process loop with a sensor-driven one.

Parameters:
MOVE_TIMEOUT  32  max cycles in MOVE without sensor_pos before fault
FILL_TIMEOUT  64  max cycles in FILL without sensor_full before fault
CAP_CYCLES    4   cycles capper is held asserted
DOZEN         12  bottles per dozen_pulse
CNT_W         8   width of bottle_count

Ports:
clk            in   1      clock
reset          in   1      asynchronous, active-low reset
start          in   1      level; begin run from IDLE
stop           in   1      pulse/level; request orderly stop
ack            in   1      clear fault (honoured only in FAULT)
sensor_pos     in   1      bottle at fill position
sensor_full    in   1      fill level reached
cap_empty      in   1      cap magazine empty
motor          out  1      conveyor on
valve          out  1      fill valve open
capper         out  1      capper actuated
state          out  3      IDLE=0 MOVE=1 FILL=2 CAP=3 FAULT=4
bottle_count   out  CNT_W  bottles completed, wraps to 0
dozen_pulse    out  1      1-cycle pulse per DOZEN bottles
alarm          out  1      high in FAULT
alarm_code     out  2      0 none, 1 move timeout, 2 fill timeout, 3 no caps

Behaviour:
- Reset (async, active-low): state=IDLE; motor, valve, capper, dozen_pulse, alarm = 0; alarm_code=0; bottle_count=0; dozen counter=0; timer=0; stop_req=0.
- Actuator outputs are registered and decoded from next state. They change in the same clock edge as state, with zero-cycle lag relative to state: motor=(MOVE), valve=(FILL), capper=(CAP).
- stop_req is set on any cycle stop=1 and cleared on entry to IDLE.
- Timer: a single counter that clears on every state change and increments every cycle otherwise.
- IDLE: start=1 and stop=0 -> MOVE. If start and stop are both high in the same cycle, stay in IDLE.
- MOVE:
  - sensor_pos=1 -> FILL.
  - Otherwise stop_req=1 -> IDLE.
  - Otherwise timer==MOVE_TIMEOUT-1 -> FAULT, code 1.
  - Priority: sensor_pos over stop_req over timeout.
- FILL:
  - sensor_full=1 -> CAP, unless cap_empty=1 in that cycle, which goes to FAULT with code 3.
  - Otherwise timer==FILL_TIMEOUT-1 -> FAULT, code 2.
  - sensor_full beats timeout when both occur in the same cycle.
  - stop_req does not abort FILL.
- CAP:
  - capper is held for exactly CAP_CYCLES cycles.
  - On the last cycle, bottle_count increments (modulo 2^CNT_W) and the dozen counter increments.
  - When the dozen counter reaches DOZEN-1 and increments, it returns to 0 and dozen_pulse=1 for exactly the next cycle.
  - Exit: stop_req=1 -> IDLE, else -> MOVE.
- FAULT:
  - All actuators 0, alarm=1, alarm_code held.
  - ack=1 -> IDLE; alarm and alarm_code clear on that transition.
  - start, stop and sensors are ignored.
  - ack is ignored outside FAULT.
- Counts persist across FAULT and IDLE. Only reset clears them.
- Reset asserted mid-operation: all outputs drop immediately (asynchronous), and counts return to 0.

Optional Feature:
Macro BATCH_LIMIT_EN.
- Defined:
  - Adds input batch_target [CNT_W-1:0] and output batch_done (1 bit, reset 0).
  - A per-run counter clears on IDLE->MOVE.
  - When it reaches batch_target at the end of CAP, the next state is IDLE and batch_done pulses for 1 cycle.
  - batch_target=0 means unlimited.
- Undefined: ports absent; runs continue until stop or fault.

Test Plan:
- Reset, then start=1, sensor_pos at MOVE cycle 3, sensor_full at FILL cycle 5 -> motor 3 cycles, valve 5 cycles, capper 4 cycles, bottle_count=1, state returns to MOVE.
- Start, sensor_pos never asserted -> FAULT after 32 MOVE cycles, alarm=1, alarm_code=1, motor=0. Then ack=1 -> IDLE, alarm=0.
- 12 complete bottles -> dozen_pulse high exactly one cycle after the 12th CAP, bottle_count=12. The 24th bottle gives a second pulse.
- cap_empty=1 when sensor_full rises -> FAULT code 3, capper never asserted, bottle_count unchanged.
- stop pulse during FILL -> fill and cap complete, bottle_count+1, then IDLE with motor=0. sensor_full and fill timeout in the same cycle -> CAP, not FAULT.
- BATCH_LIMIT_EN with batch_target=3 -> after 3 bottles state=IDLE and batch_done pulses once. Reset asserted mid-FILL -> valve=0 immediately, counts=0.

Source files
------------

// File: rtl/ctrl_envase.sv
// ctrl_envase: sensor-driven sequencer for one bottling station.
// The station moves a bottle into position (conveyor motor), fills it
// (fill valve) and caps it (capper), then counts it. MOVE and FILL each
// have a timeout. A timeout or an empty cap magazine latches a fault that
// stays until the operator acknowledges it.
// Optional feature macro: BATCH_LIMIT_EN. When it is defined, the block
// gains the batch_target input and the batch_done output, and a run stops
// on its own after batch_target bottles.
module ctrl_envase #(
  parameter int MOVE_TIMEOUT = 32,
  parameter int FILL_TIMEOUT = 64,
  parameter int CAP_CYCLES   = 4,
  parameter int DOZEN        = 12,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  input  logic             sensor_pos,
  input  logic             sensor_full,
  input  logic             cap_empty,
`ifdef BATCH_LIMIT_EN
  input  logic [CNT_W-1:0] batch_target,
  output logic             batch_done,
`endif
  output logic             motor,
  output logic             valve,
  output logic             capper,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] bottle_count,
  output logic             dozen_pulse,
  output logic             alarm,
  output logic [1:0]       alarm_code
);

  // One shared step timer. It must hold the largest step length.
  localparam int TMR_MAX_MC = (MOVE_TIMEOUT > CAP_CYCLES) ? MOVE_TIMEOUT : CAP_CYCLES;
  localparam int TMR_MAX    = (FILL_TIMEOUT > TMR_MAX_MC) ? FILL_TIMEOUT : TMR_MAX_MC;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam int DZ_W       = $clog2(DOZEN + 1);

  localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] FILL_LAST = TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CAP_LAST  = TMR_W'(CAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [DZ_W-1:0]  DZ_LAST   = DZ_W'(DOZEN - 1);
  localparam logic [DZ_W-1:0]  DZ_ONE    = DZ_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_FILL  = 3'd2,
    ST_CAP   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             stop_req_q, stop_req_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DZ_W-1:0]  dozen_q, dozen_d;
  logic             dozen_pulse_q, dozen_pulse_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       fault_code_s;
  logic             motor_q, valve_q, capper_q, alarm_q;
  logic             cap_done_s;
  logic             batch_hit_s;

`ifdef BATCH_LIMIT_EN
  logic [CNT_W-1:0] run_q, run_d;
  logic             batch_done_q, batch_done_d;

  // The bottle that is finishing completes the batch (a target of zero means no limit).
  always_comb begin
    batch_hit_s = 1'b0;
    if (batch_target != {CNT_W{1'b0}}) begin
      batch_hit_s = ((run_q + CNT_ONE) == batch_target);
    end else begin
      batch_hit_s = 1'b0;
    end
  end

  // Per-run bottle counter: it restarts on every new run and advances on each capped bottle.
  always_comb begin
    run_d        = run_q;
    batch_done_d = 1'b0;
    if ((state_q == ST_IDLE) && (state_d == ST_MOVE)) begin
      run_d = {CNT_W{1'b0}};
    end else if (cap_done_s) begin
      run_d        = run_q + CNT_ONE;
      batch_done_d = batch_hit_s;
    end else begin
      run_d = run_q;
    end
  end

  // Batch registers: the done flag is a one-cycle pulse after the last bottle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q        <= {CNT_W{1'b0}};
      batch_done_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      batch_done_q <= batch_done_d;
    end
  end

  assign batch_done = batch_done_q;
`else
  // Without the batch feature a run never ends on a bottle count.
  always_comb begin
    batch_hit_s = 1'b0;
  end
`endif

  // Next-state decision. Order of precedence: sensors, then stop, then timeout.
  always_comb begin
    state_d      = state_q;
    fault_code_s = 2'd0;
    cap_done_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_MOVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (sensor_pos) begin
          state_d = ST_FILL;
        end else if (stop_req_q) begin
          state_d = ST_IDLE;
        end else if (timer_q == MOVE_LAST) begin
          state_d      = ST_FAULT;
          fault_code_s = 2'd1;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_FILL: begin
        // A started fill always runs to completion. Stop is honoured after capping.
        if (sensor_full) begin
          if (cap_empty) begin
            state_d      = ST_FAULT;
            fault_code_s = 2'd3;
          end else begin
            state_d = ST_CAP;
          end
        end else if (timer_q == FILL_LAST) begin
          state_d      = ST_FAULT;
          fault_code_s = 2'd2;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_CAP: begin
        if (timer_q == CAP_LAST) begin
          cap_done_s = 1'b1;
          if (stop_req_q || batch_hit_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MOVE;
          end
        end else begin
          state_d = ST_CAP;
        end
      end
      ST_FAULT: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: step timer, stop request, fault code, bottle and dozen counts.
  always_comb begin
    // The timer restarts on every change of step.
    if (state_d != state_q) begin
      timer_d = {TMR_W{1'b0}};
    end else begin
      timer_d = timer_q + TMR_ONE;
    end

    // A stop request is remembered until the controller is back in IDLE.
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      stop_req_d = 1'b0;
    end else if (stop) begin
      stop_req_d = 1'b1;
    end else begin
      stop_req_d = stop_req_q;
    end

    // The fault code is latched on entry to FAULT, held there and cleared on leaving.
    if (state_d == ST_FAULT) begin
      if (state_q == ST_FAULT) begin
        code_d = code_q;
      end else begin
        code_d = fault_code_s;
      end
    end else begin
      code_d = 2'd0;
    end

    // Count the bottle on the last capping cycle. The dozen pulse follows the twelfth bottle.
    if (cap_done_s) begin
      count_d = count_q + CNT_ONE;
      if (dozen_q == DZ_LAST) begin
        dozen_d       = {DZ_W{1'b0}};
        dozen_pulse_d = 1'b1;
      end else begin
        dozen_d       = dozen_q + DZ_ONE;
        dozen_pulse_d = 1'b0;
      end
    end else begin
      count_d       = count_q;
      dozen_d       = dozen_q;
      dozen_pulse_d = 1'b0;
    end
  end

  // State and registered outputs. Actuators decode the next state so they switch with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= {TMR_W{1'b0}};
      stop_req_q    <= 1'b0;
      count_q       <= {CNT_W{1'b0}};
      dozen_q       <= {DZ_W{1'b0}};
      dozen_pulse_q <= 1'b0;
      code_q        <= 2'd0;
      motor_q       <= 1'b0;
      valve_q       <= 1'b0;
      capper_q      <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stop_req_q    <= stop_req_d;
      count_q       <= count_d;
      dozen_q       <= dozen_d;
      dozen_pulse_q <= dozen_pulse_d;
      code_q        <= code_d;
      motor_q       <= (state_d == ST_MOVE);
      valve_q       <= (state_d == ST_FILL);
      capper_q      <= (state_d == ST_CAP);
      alarm_q       <= (state_d == ST_FAULT);
    end
  end

  assign state        = state_q;
  assign motor        = motor_q;
  assign valve        = valve_q;
  assign capper       = capper_q;
  assign bottle_count = count_q;
  assign dozen_pulse  = dozen_pulse_q;
  assign alarm        = alarm_q;
  assign alarm_code   = code_q;

endmodule

// File: tb/tb_ctrl_envase.sv
// Self-checking bench for ctrl_envase. It uses a table of directed vectors,
// hand-written sequences for the multi-cycle corner cases, and a random
// phase that is compared every cycle against a behavioural model.
module tb_ctrl_envase;
  localparam int MOVE_TO = 32;
  localparam int FILL_TO = 64;
  localparam int CAPC    = 4;
  localparam int DOZ     = 12;
  localparam int CW      = 8;

  localparam int P_IDLE = 0, P_MOVE = 1, P_FILL = 2, P_CAP = 3, P_FAULT = 4;

  logic clk = 1'b0;
  logic reset, start, stop, ack, sensor_pos, sensor_full, cap_empty;
  logic motor, valve, capper, dozen_pulse, alarm;
  logic [2:0] state;
  logic [CW-1:0] bottle_count;
  logic [1:0] alarm_code;
`ifdef BATCH_LIMIT_EN
  logic [CW-1:0] batch_target;
  logic batch_done;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: current phase, cycles spent in it, bottles finished ever, and so on.
  int m_ph, m_age, m_total, m_code, m_run;
  bit m_sreq, m_pulse, m_bdone;

  ctrl_envase dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack),
    .sensor_pos(sensor_pos), .sensor_full(sensor_full), .cap_empty(cap_empty),
`ifdef BATCH_LIMIT_EN
    .batch_target(batch_target), .batch_done(batch_done),
`endif
    .motor(motor), .valve(valve), .capper(capper), .state(state),
    .bottle_count(bottle_count), .dozen_pulse(dozen_pulse),
    .alarm(alarm), .alarm_code(alarm_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_age = 1; m_total = 0; m_code = 0; m_run = 0;
    m_sreq = 1'b0; m_pulse = 1'b0; m_bdone = 1'b0;
  endtask

  // Advance the model by one cycle, using the inputs that are currently applied.
  task automatic m_step();
    int nph;
    int ncode;
    nph = m_ph; ncode = m_code; m_pulse = 1'b0; m_bdone = 1'b0;
    case (m_ph)
      P_IDLE:  if (start && !stop) nph = P_MOVE;
      P_MOVE: begin
        if (sensor_pos) nph = P_FILL;
        else if (m_sreq) nph = P_IDLE;
        else if (m_age == MOVE_TO) begin nph = P_FAULT; ncode = 1; end
      end
      P_FILL: begin
        if (sensor_full) begin
          if (cap_empty) begin nph = P_FAULT; ncode = 3; end
          else nph = P_CAP;
        end else if (m_age == FILL_TO) begin nph = P_FAULT; ncode = 2; end
      end
      P_CAP: begin
        if (m_age == CAPC) begin
          m_total++;
          m_run++;
          m_pulse = ((m_total % DOZ) == 0);
          nph = m_sreq ? P_IDLE : P_MOVE;
`ifdef BATCH_LIMIT_EN
          if (batch_target != 0 && (m_run % 256) == int'(batch_target)) begin
            nph = P_IDLE; m_bdone = 1'b1;
          end
`endif
        end
      end
      P_FAULT: if (ack) nph = P_IDLE;
      default: nph = P_IDLE;
    endcase
    if (nph == P_IDLE && m_ph != P_IDLE) m_sreq = 1'b0;
    else if (stop) m_sreq = 1'b1;
    if (m_ph == P_IDLE && nph == P_MOVE) m_run = 0;
    if (nph != P_FAULT) ncode = 0;
    m_age  = (nph == m_ph) ? m_age + 1 : 1;
    m_code = ncode;
    m_ph   = nph;
  endtask

  task automatic compare_all();
    check("state",   state, m_ph);
    check("motor",   motor, (m_ph == P_MOVE));
    check("valve",   valve, (m_ph == P_FILL));
    check("capper",  capper, (m_ph == P_CAP));
    check("count",   bottle_count, m_total % 256);
    check("dozen",   dozen_pulse, m_pulse);
    check("alarm",   alarm, (m_ph == P_FAULT));
    check("code",    alarm_code, m_code);
`ifdef BATCH_LIMIT_EN
    check("bdone",   batch_done, m_bdone);
`endif
  endtask

  // One clock: the model steps, the DUT takes an edge, and outputs are compared 1 time unit later.
  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clr_inputs();
    start = 1'b0; stop = 1'b0; ack = 1'b0;
    sensor_pos = 1'b0; sensor_full = 1'b0; cap_empty = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_motor", motor, 0);
    check("rst_valve", valve, 0);
    check("rst_count", bottle_count, 0);
    check("rst_alarm", alarm, 0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic       st, pos, full;
    logic [2:0] e_state;
    logic       e_m, e_v, e_c;
    int         e_cnt;
  } vec_t;

  function automatic vec_t mk(logic st, logic pos, logic full, logic [2:0] es,
                              logic em, logic ev, logic ec, int ecnt);
    vec_t v;
    v.st = st; v.pos = pos; v.full = full; v.e_state = es;
    v.e_m = em; v.e_v = ev; v.e_c = ec; v.e_cnt = ecnt;
    return v;
  endfunction

  vec_t tbl[14];
  int n_motor, n_valve, n_capper, n_pulse, n_bd;
  int pulse_cnt[2];

  initial begin
    reset = 1'b0;
    clr_inputs();
`ifdef BATCH_LIMIT_EN
    batch_target = '0;
`endif
    m_reset();
    #2;
    check("init_state", state, 0);
    check("init_code", alarm_code, 0);
    check("init_dozen", dozen_pulse, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Basic bottle: sensor_pos in MOVE cycle 3, sensor_full in FILL cycle 5.
    tbl[0]  = mk(1, 0, 0, 3'd1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 3'd1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 3'd1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 3'd2, 0, 1, 0, 0);
    for (int i = 4; i < 8; i++) tbl[i] = mk(0, 0, 0, 3'd2, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 3'd3, 0, 0, 1, 0);
    for (int i = 9; i < 12; i++) tbl[i] = mk(0, 0, 0, 3'd3, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 3'd1, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 3'd1, 1, 0, 0, 1);
    n_motor = 0; n_valve = 0; n_capper = 0;
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st; sensor_pos = tbl[i].pos; sensor_full = tbl[i].full;
      cyc();
      check("tv_state", state, tbl[i].e_state);
      check("tv_motor", motor, tbl[i].e_m);
      check("tv_valve", valve, tbl[i].e_v);
      check("tv_capper", capper, tbl[i].e_c);
      check("tv_count", bottle_count, tbl[i].e_cnt);
      if (i < 12) begin
        n_motor += int'(motor); n_valve += int'(valve); n_capper += int'(capper);
      end
    end
    check("tv_motor_cycles", n_motor, 3);
    check("tv_valve_cycles", n_valve, 5);
    check("tv_capper_cycles", n_capper, 4);

    // MOVE timeout: 32 MOVE cycles, then FAULT with code 1. Inputs are ignored until ack.
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 31; i++) cyc();
    check("mto_still_move", state, 1);
    cyc();
    check("mto_state", state, 4);
    check("mto_alarm", alarm, 1);
    check("mto_code", alarm_code, 1);
    check("mto_motor", motor, 0);
    start = 1'b1; stop = 1'b1; sensor_pos = 1'b1;
    cyc(); cyc();
    check("fault_hold", state, 4);
    clr_inputs();
    ack = 1'b1; cyc(); ack = 1'b0;
    check("ack_state", state, 0);
    check("ack_alarm", alarm, 0);
    check("ack_code", alarm_code, 0);

    // Dozen pulses: 24 fast bottles at 6 cycles each.
    start = 1'b1; sensor_pos = 1'b1; sensor_full = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 146; i++) begin
      cyc();
      if (dozen_pulse === 1'b1) begin
        if (n_pulse < 2) pulse_cnt[n_pulse] = int'(bottle_count);
        n_pulse++;
      end
    end
    check("dozen_pulses", n_pulse, 2);
    check("dozen_at_12", pulse_cnt[0], 12);
    check("dozen_at_24", pulse_cnt[1], 24);
    check("dozen_count", bottle_count, 24);
    start = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("stop_idle", state, 0);
    check("stop_motor", motor, 0);
    check("stop_count", bottle_count, 25);
    clr_inputs(); cyc();

    // Empty cap magazine at the moment the bottle is full.
    start = 1'b1; cyc(); start = 1'b0;
    sensor_pos = 1'b1; cyc(); sensor_pos = 1'b0;
    cyc();
    sensor_full = 1'b1; cap_empty = 1'b1; cyc();
    check("ce_state", state, 4);
    check("ce_code", alarm_code, 3);
    check("ce_capper", capper, 0);
    clr_inputs(); cyc(); cyc();
    check("ce_count", bottle_count, 25);
    ack = 1'b1; cyc(); ack = 1'b0;
    check("ce_ack", state, 0);

    // Stop pulse during FILL: the fill and cap still complete, then IDLE.
    start = 1'b1; cyc(); start = 1'b0;
    sensor_pos = 1'b1; cyc(); sensor_pos = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc();
    check("sf_in_fill", state, 2);
    sensor_full = 1'b1; cyc(); sensor_full = 1'b0;
    check("sf_cap", state, 3);
    for (int i = 0; i < 4; i++) cyc();
    check("sf_idle", state, 0);
    check("sf_motor", motor, 0);
    check("sf_count", bottle_count, 26);

    // sensor_full arrives in the same cycle as the fill timeout: CAP wins.
    start = 1'b1; cyc(); start = 1'b0;
    sensor_pos = 1'b1; cyc(); sensor_pos = 1'b0;
    for (int i = 0; i < 63; i++) cyc();
    check("ft_still_fill", state, 2);
    sensor_full = 1'b1; cyc(); sensor_full = 1'b0;
    check("ft_cap", state, 3);
    check("ft_alarm", alarm, 0);
    for (int i = 0; i < 4; i++) cyc();
    check("ft_count", bottle_count, 27);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
    check("ft_idle", state, 0);

    // Reset asserted in the middle of FILL: outputs drop at once.
    start = 1'b1; cyc(); start = 1'b0;
    sensor_pos = 1'b1; cyc(); sensor_pos = 1'b0;
    cyc();
    check("mr_valve_before", valve, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mr_valve", valve, 0);
    check("mr_state", state, 0);
    check("mr_count", bottle_count, 0);
    clr_inputs();
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // start and stop together keep the controller in IDLE.
    start = 1'b1; stop = 1'b1; cyc();
    check("ss_idle", state, 0);
    clr_inputs(); cyc();

    // Random phase, checked against the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom_range(99) < 30);
      stop        = ($urandom_range(99) < 3);
      ack         = ($urandom_range(99) < 20);
      sensor_pos  = ($urandom_range(99) < 25);
      sensor_full = ($urandom_range(99) < 10);
      cap_empty   = ($urandom_range(99) < 5);
      cyc();
    end

`ifdef BATCH_LIMIT_EN
    // Batch of 3: the run ends on its own and batch_done pulses once.
    batch_target = 8'd3;
    do_reset();
    start = 1'b1; sensor_pos = 1'b1; sensor_full = 1'b1;
    cyc(); start = 1'b0;
    n_bd = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (batch_done === 1'b1) n_bd++;
    end
    check("batch_pulses", n_bd, 1);
    check("batch_idle", state, 0);
    check("batch_count", bottle_count, 3);
    batch_target = 8'd0;
    clr_inputs();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
